// File: rtl/lcd_clock_pkg.sv
// HD44780 command/character constants, BCD time bundle and sequencer state enum shared by the LCD writer.
package lcd_clock_pkg;

  localparam logic [7:0] FUNC_SET_4B = 8'h28;
  localparam logic [7:0] DISP_ON     = 8'h0C;
  localparam logic [7:0] ENTRY_INC   = 8'h06;
  localparam logic [7:0] CLEAR       = 8'h01;
  localparam logic [7:0] SET_DDRAM   = 8'h80;
  localparam logic [7:0] CHAR_COLON  = 8'h3A;
  localparam logic [7:0] CHAR_ERR    = 8'h3F;

  typedef enum logic [1:0] {
    ST_PWRUP,
    ST_INIT,
    ST_IDLE,
    ST_REFRESH
  } seq_state_t;

  typedef struct packed {
    logic [3:0] hours_tens;
    logic [3:0] hours_ones;
    logic [3:0] minutes_tens;
    logic [3:0] minutes_ones;
    logic [3:0] seconds_tens;
    logic [3:0] seconds_ones;
  } bcd_time_t;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : CHAR_ERR;
  endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// Drives one LCD nibble: 1 setup cycle, E_PULSE_CYCLES of lcd_e, 1 hold cycle, then post_wait_cycles+1 idle.
// done pulses in the last wait cycle; start is only honoured while idle.
module lcd_nibble_writer #(
  parameter int E_PULSE_CYCLES = 25,
  parameter int WAIT_W         = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              rs,
  input  logic [3:0]        nibble,
  input  logic [WAIT_W-1:0] post_wait_cycles,
  output logic              done,
  output logic              lcd_e,
  output logic              lcd_rs,
  output logic [3:0]        lcd_data
);

  typedef enum logic [2:0] {
    NW_IDLE,
    NW_SETUP,
    NW_EHI,
    NW_HOLD,
    NW_WAIT
  } nw_state_t;

  localparam logic [WAIT_W-1:0] E_LAST = WAIT_W'(E_PULSE_CYCLES - 1);

  nw_state_t         state, state_nxt;
  logic [WAIT_W-1:0] cnt;
  logic [WAIT_W-1:0] wait_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= NW_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      NW_IDLE:  if (start) state_nxt = NW_SETUP;
      NW_SETUP: state_nxt = NW_EHI;
      NW_EHI:   if (cnt == '0) state_nxt = NW_HOLD;
      NW_HOLD:  state_nxt = NW_WAIT;
      NW_WAIT:  if (cnt == '0) state_nxt = NW_IDLE;
      default:  state_nxt = NW_IDLE;
    endcase
    done  = (state == NW_WAIT) && (cnt == '0);
    lcd_e = (state == NW_EHI);
  end

  // rs/data are latched at start and left untouched until the next start, covering setup and hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      wait_q   <= '0;
      lcd_rs   <= 1'b0;
      lcd_data <= 4'h0;
    end else begin
      case (state)
        NW_IDLE: if (start) begin
          lcd_rs   <= rs;
          lcd_data <= nibble;
          wait_q   <= post_wait_cycles;
        end
        NW_SETUP: cnt <= E_LAST;
        NW_HOLD:  cnt <= wait_q;
        NW_EHI, NW_WAIT: if (cnt != '0) cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/lcd_time_writer.sv
// Runs HD44780 4-bit init once, then rewrites "HH:MM:SS" on line 1 whenever the BCD digits differ from the snapshot.
// First lcd_e rise 2 cycles after capture; digit changes during a refresh are picked up on return to IDLE.
module lcd_time_writer
  import lcd_clock_pkg::*;
#(
  parameter int         CLOCK_FREQ      = 50_000_000,
  parameter int         POWERUP_WAIT_MS = 20,
  parameter int         E_PULSE_CYCLES  = 25,
  parameter int         CMD_WAIT_US     = 50,
  parameter int         CLEAR_WAIT_US   = 2000,
  parameter logic [6:0] DISPLAY_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] bcd_hours_tens,
  input  logic [3:0] bcd_hours_ones,
  input  logic [3:0] bcd_minutes_tens,
  input  logic [3:0] bcd_minutes_ones,
  input  logic [3:0] bcd_seconds_tens,
  input  logic [3:0] bcd_seconds_ones,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [3:0] lcd_data,
  output logic       init_done,
  output logic       busy
);

  localparam int US_CYC  = CLOCK_FREQ / 1_000_000;
  localparam int PWR_CYC = POWERUP_WAIT_MS * 1000 * US_CYC;
  localparam int W       = $clog2(PWR_CYC + 5000 * US_CYC + CLEAR_WAIT_US * US_CYC + 2);

  localparam logic [W-1:0] PWR_LAST  = W'(PWR_CYC - 1);
  localparam logic [W-1:0] CYC_US    = W'(US_CYC);
  localparam logic [W-1:0] CYC_5MS   = W'(5000 * US_CYC);
  localparam logic [W-1:0] CYC_200US = W'(200 * US_CYC);
  localparam logic [W-1:0] CYC_CMD   = W'(CMD_WAIT_US * US_CYC);
  localparam logic [W-1:0] CYC_CLEAR = W'(CLEAR_WAIT_US * US_CYC);

  seq_state_t   state, state_nxt;
  bcd_time_t    live, snap;
  logic [W-1:0] pwr_cnt;
  logic [3:0]   step;
  logic         half, kick;
  logic [7:0]   cur_byte;
  logic         cur_rs, single, last_step, item_end, seq_end;
  logic [W-1:0] single_wait, post_wait;
  logic [3:0]   nib;
  logic         nw_done;

  assign live   = {bcd_hours_tens, bcd_hours_ones, bcd_minutes_tens,
                   bcd_minutes_ones, bcd_seconds_tens, bcd_seconds_ones};
  assign lcd_rw = 1'b0;
  assign busy   = (state != ST_IDLE);

  // Step table: INIT steps 0..3 are lone high nibbles, everything else is a full byte.
  always_comb begin
    cur_byte    = 8'h00;
    cur_rs      = 1'b0;
    single      = 1'b0;
    single_wait = '0;
    if (state == ST_INIT) begin
      case (step)
        4'd0:    begin cur_byte = 8'h30; single = 1'b1; single_wait = CYC_5MS;   end
        4'd1:    begin cur_byte = 8'h30; single = 1'b1; single_wait = CYC_200US; end
        4'd2:    begin cur_byte = 8'h30; single = 1'b1; single_wait = CYC_CMD;   end
        4'd3:    begin cur_byte = 8'h20; single = 1'b1; single_wait = CYC_CMD;   end
        4'd4:    cur_byte = FUNC_SET_4B;
        4'd5:    cur_byte = DISP_ON;
        4'd6:    cur_byte = ENTRY_INC;
        default: cur_byte = CLEAR;
      endcase
    end else begin
      cur_rs = (step != 4'd0);
      case (step)
        4'd0:       cur_byte = SET_DDRAM | {1'b0, DISPLAY_ADDR};
        4'd1:       cur_byte = digit_char(snap.hours_tens);
        4'd2:       cur_byte = digit_char(snap.hours_ones);
        4'd4:       cur_byte = digit_char(snap.minutes_tens);
        4'd5:       cur_byte = digit_char(snap.minutes_ones);
        4'd7:       cur_byte = digit_char(snap.seconds_tens);
        4'd8:       cur_byte = digit_char(snap.seconds_ones);
        default:    cur_byte = CHAR_COLON;
      endcase
    end
    nib       = half ? cur_byte[3:0] : cur_byte[7:4];
    post_wait = single ? single_wait :
                !half  ? CYC_US :
                (cur_byte == CLEAR && !cur_rs) ? CYC_CLEAR : CYC_CMD;
    last_step = (state == ST_INIT) ? (step == 4'd7) : (step == 4'd8);
    item_end  = nw_done && (single || half);
    seq_end   = item_end && last_step;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_PWRUP;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_PWRUP:   if (pwr_cnt >= PWR_LAST) state_nxt = ST_INIT;
      ST_INIT:    if (seq_end) state_nxt = ST_REFRESH;
      ST_IDLE:    if (live != snap) state_nxt = ST_REFRESH;
      ST_REFRESH: if (seq_end) state_nxt = ST_IDLE;
      default:    state_nxt = ST_PWRUP;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwr_cnt   <= '0;
      step      <= 4'd0;
      half      <= 1'b0;
      kick      <= 1'b0;
      snap      <= '0;
      init_done <= 1'b0;
    end else begin
      kick <= 1'b0;
      if (state == ST_PWRUP && pwr_cnt != '1) pwr_cnt <= pwr_cnt + 1'b1;
      if (state != state_nxt) begin
        step <= 4'd0;
        half <= 1'b0;
        kick <= (state_nxt == ST_INIT) || (state_nxt == ST_REFRESH);
        if (state_nxt == ST_REFRESH) snap <= live;
        if (state == ST_INIT) init_done <= 1'b1;
      end else if (nw_done) begin
        kick <= 1'b1;
        if (item_end) begin
          half <= 1'b0;
          step <= step + 4'd1;
        end else begin
          half <= 1'b1;
        end
      end
    end
  end

  lcd_nibble_writer #(
    .E_PULSE_CYCLES (E_PULSE_CYCLES),
    .WAIT_W         (W)
  ) u_nibble (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (kick),
    .rs               (cur_rs),
    .nibble           (nib),
    .post_wait_cycles (post_wait),
    .done             (nw_done),
    .lcd_e            (lcd_e),
    .lcd_rs           (lcd_rs),
    .lcd_data         (lcd_data)
  );

endmodule

// File: tb/tb_lcd_time_writer.sv
// Bench for lcd_time_writer: decodes nibbles on lcd_e falls and compares against the expected LCD byte stream.
module tb_lcd_time_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:0] dg;
  logic        lcd_rs, lcd_rw, lcd_e, init_done, busy;
  logic [3:0]  lcd_data;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic       q_rs[$];
  logic [3:0] q_nib[$];
  int         q_t[$];

  always #5 clk = ~clk;

  lcd_time_writer #(
    .CLOCK_FREQ     (1_000_000),
    .E_PULSE_CYCLES (2)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .bcd_hours_tens   (dg[23:20]),
    .bcd_hours_ones   (dg[19:16]),
    .bcd_minutes_tens (dg[15:12]),
    .bcd_minutes_ones (dg[11:8]),
    .bcd_seconds_tens (dg[7:4]),
    .bcd_seconds_ones (dg[3:0]),
    .lcd_rs           (lcd_rs),
    .lcd_rw           (lcd_rw),
    .lcd_e            (lcd_e),
    .lcd_data         (lcd_data),
    .init_done        (init_done),
    .busy             (busy)
  );

  // Pin monitor: checks pulse width, setup/hold and rw on every nibble, queues the decoded nibble.
  logic       m_prev_e = 1'b0, m_prev_rs = 1'b0, m_rs = 1'b0, m_ok = 1'b1, m_rw_bad = 1'b0;
  logic [3:0] m_prev_dat = 4'h0, m_dat = 4'h0;
  int         m_w = 0;

  always @(negedge clk) begin
    cyc++;
    if (reset_n === 1'b1) begin
      if (lcd_e && !m_prev_e) begin
        m_rs  = lcd_rs;
        m_dat = lcd_data;
        m_w   = 1;
        m_ok  = (lcd_rs === m_prev_rs) && (lcd_data === m_prev_dat);
      end else if (lcd_e) begin
        m_w++;
        if (lcd_rs !== m_rs || lcd_data !== m_dat) m_ok = 1'b0;
      end else if (m_prev_e) begin
        if (lcd_rs !== m_rs || lcd_data !== m_dat) m_ok = 1'b0;
        vectors++;
        if (!m_ok || m_w != 2 || m_rw_bad) begin
          miscompares++;
          $display("FAIL nibble_timing: width=%0d (want 2) setup_hold_ok=%0b (want 1) rw_high=%0b (want 0)",
                   m_w, m_ok, m_rw_bad);
        end
        q_rs.push_back(m_rs);
        q_nib.push_back(m_dat);
        q_t.push_back(cyc);
        m_rw_bad = 1'b0;
      end
      if (lcd_rw !== 1'b0) m_rw_bad = 1'b1;
    end
    m_prev_e   = lcd_e;
    m_prev_rs  = lcd_rs;
    m_prev_dat = lcd_data;
  end

  function automatic logic [7:0] ch(input logic [3:0] d);
    return (d < 4'd10) ? (8'd48 + {4'd0, d}) : 8'h3F;
  endfunction

  function automatic logic [23:0] rnd_time();
    logic [23:0] r;
    for (int i = 0; i < 6; i++) r[i*4 +: 4] = 4'($urandom_range(0, 11));
    return r;
  endfunction

  task automatic expect_nibble(input string name, input logic exp_rs, input logic [3:0] exp_nib,
                               input int max_cyc, output int t);
    int n = 0;
    logic r;
    logic [3:0] v;
    while (q_nib.size() == 0 && n < max_cyc) begin
      @(negedge clk); #1; n++;
    end
    vectors++;
    if (q_nib.size() == 0) begin
      miscompares++;
      t = cyc;
      $display("FAIL %s: no nibble within %0d cycles, expected rs=%0b nib=%h", name, max_cyc, exp_rs, exp_nib);
    end else begin
      r = q_rs.pop_front();
      v = q_nib.pop_front();
      t = q_t.pop_front();
      if (r !== exp_rs || v !== exp_nib) begin
        miscompares++;
        $display("FAIL %s: got rs=%0b nib=%h, expected rs=%0b nib=%h", name, r, v, exp_rs, exp_nib);
      end
    end
  endtask

  task automatic expect_byte(input string name, input logic exp_rs, input logic [7:0] b,
                             input int max_cyc, output int t_hi, output int t_lo);
    expect_nibble({name, "_hi"}, exp_rs, b[7:4], max_cyc, t_hi);
    expect_nibble({name, "_lo"}, exp_rs, b[3:0], 50, t_lo);
  endtask

  // Expected line is built from the digits the refresh is expected to snapshot; optionally
  // changes the live digits before byte chg_idx to exercise the no-tearing rule.
  task automatic expect_line(input string name, input logic [23:0] d, input int max_first,
                             input int chg_idx, input logic [23:0] chg_d,
                             output int t_first, output int t_last);
    logic [7:0] eb [9];
    int th, tl;
    eb[0] = 8'h84;
    eb[1] = ch(d[23:20]); eb[2] = ch(d[19:16]); eb[3] = 8'h3A;
    eb[4] = ch(d[15:12]); eb[5] = ch(d[11:8]);  eb[6] = 8'h3A;
    eb[7] = ch(d[7:4]);   eb[8] = ch(d[3:0]);
    t_first = 0;
    t_last  = 0;
    for (int i = 0; i < 9; i++) begin
      if (i == chg_idx) dg = chg_d;
      expect_byte($sformatf("%s_b%0d", name, i), (i != 0), eb[i], (i == 0) ? max_first : 300, th, tl);
      if (i == 0) t_first = th;
      t_last = tl;
    end
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int n = 0;
    while (busy !== 1'b0 && n < max_cyc) begin
      @(negedge clk); #1; n++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: busy=%b after %0d cycles, expected 0", name, busy, max_cyc);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    dg      = 24'h0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    vectors += 6;
    if (lcd_e !== 1'b0)     begin miscompares++; $display("FAIL reset_e: got %b expected 0", lcd_e); end
    if (lcd_rs !== 1'b0)    begin miscompares++; $display("FAIL reset_rs: got %b expected 0", lcd_rs); end
    if (lcd_rw !== 1'b0)    begin miscompares++; $display("FAIL reset_rw: got %b expected 0", lcd_rw); end
    if (lcd_data !== 4'h0)  begin miscompares++; $display("FAIL reset_data: got %h expected 0", lcd_data); end
    if (init_done !== 1'b0) begin miscompares++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
    if (busy !== 1'b1)      begin miscompares++; $display("FAIL reset_busy: got %b expected 1", busy); end
    reset_n = 1'b1;
  endtask

  task automatic test_init(input string name);
    int t, th, tclr, tf, tl;
    repeat (20000) @(negedge clk);
    #1;
    vectors++;
    if (q_nib.size() != 0 || lcd_e !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_pwrup_quiet: %0d nibbles, lcd_e=%b within 20000 cycles, expected none", name, q_nib.size(), lcd_e);
    end
    expect_nibble({name, "_n0"}, 1'b0, 4'h3, 200, t);
    expect_nibble({name, "_n1"}, 1'b0, 4'h3, 5100, t);
    expect_nibble({name, "_n2"}, 1'b0, 4'h3, 300, t);
    expect_nibble({name, "_n3"}, 1'b0, 4'h2, 200, t);
    expect_byte({name, "_28"}, 1'b0, 8'h28, 200, th, t);
    expect_byte({name, "_0c"}, 1'b0, 8'h0C, 200, th, t);
    expect_byte({name, "_06"}, 1'b0, 8'h06, 200, th, t);
    expect_byte({name, "_01"}, 1'b0, 8'h01, 200, th, tclr);
    vectors++;
    if (init_done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_done_early: init_done=%b during clear wait, expected 0", name, init_done);
    end
    expect_line({name, "_line"}, dg, 2300, -1, dg, tf, tl);
    vectors += 2;
    if (tf - tclr < 2000) begin
      miscompares++;
      $display("FAIL %s_clear_gap: %0d cycles, expected >= 2000", name, tf - tclr);
    end
    if (init_done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_init_done: got %b expected 1", name, init_done);
    end
    wait_idle({name, "_idle"}, 200);
  endtask

  task automatic test_set_time();
    int t0, tf, tl;
    @(negedge clk); #1;
    t0 = cyc;
    dg = 24'h235958;
    expect_line("set_time", dg, 20, -1, dg, tf, tl);
    vectors++;
    if (tf - t0 > 6) begin
      miscompares++;
      $display("FAIL first_e_latency: first fall %0d cycles after change, expected <= 6", tf - t0);
    end
    wait_idle("set_time_idle", 200);
    repeat (5000) @(negedge clk);
    #1;
    vectors++;
    if (q_nib.size() != 0 || lcd_e !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_quiet: %0d nibbles lcd_e=%b, expected none", q_nib.size(), lcd_e);
    end
  endtask

  task automatic test_mid_refresh();
    int tf1, tl1, tf2, tl2;
    dg = 24'h215958;
    expect_line("mid_first", 24'h215958, 20, 4, 24'h215959, tf1, tl1);
    expect_line("mid_second", 24'h215959, 120, -1, dg, tf2, tl2);
    vectors++;
    if (tf2 - tl1 > 100) begin
      miscompares++;
      $display("FAIL rerefresh_gap: %0d cycles, expected <= 100", tf2 - tl1);
    end
    wait_idle("mid_idle", 200);
  endtask

  task automatic test_bad_digit();
    int tf, tl;
    dg = 24'hA15959;
    expect_line("bad_digit", dg, 20, -1, dg, tf, tl);
    wait_idle("bad_digit_idle", 200);
  endtask

  task automatic test_random();
    int tf, tl, ci;
    logic [23:0] nd, cd;
    for (int k = 0; k < 6; k++) begin
      nd = rnd_time();
      if (nd == dg) nd[3:0] = nd[3:0] ^ 4'h1;
      dg = nd;
      if ($urandom_range(0, 1) == 1) begin
        ci = $urandom_range(1, 8);
        cd = rnd_time();
        if (cd == nd) cd[23:20] = cd[23:20] ^ 4'h1;
        expect_line($sformatf("rnd%0d_a", k), nd, 20, ci, cd, tf, tl);
        expect_line($sformatf("rnd%0d_b", k), cd, 120, -1, cd, tf, tl);
      end else begin
        expect_line($sformatf("rnd%0d", k), nd, 20, -1, nd, tf, tl);
      end
      wait_idle($sformatf("rnd%0d_idle", k), 200);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    dg = dg ^ 24'h000011;
    while (q_nib.size() < 4 && n < 400) begin
      @(negedge clk); #1; n++;
    end
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (lcd_e !== 1'b1 && n < 100);
    vectors++;
    if (lcd_e !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_e_high: lcd_e=%b, expected 1 before reset", lcd_e);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors += 3;
    if (lcd_e !== 1'b0)     begin miscompares++; $display("FAIL reset_mid_e: got %b expected 0", lcd_e); end
    if (init_done !== 1'b0) begin miscompares++; $display("FAIL reset_mid_init_done: got %b expected 0", init_done); end
    if (busy !== 1'b1)      begin miscompares++; $display("FAIL reset_mid_busy: got %b expected 1", busy); end
    repeat (3) @(negedge clk);
    q_rs.delete();
    q_nib.delete();
    q_t.delete();
    #1 reset_n = 1'b1;
    test_init("reinit");
  endtask

  initial begin
    test_reset();
    test_init("init");
    test_set_time();
    test_mid_refresh();
    test_bad_digit();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
